hilo_unit: RTL and testbench
============================

HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset, with ports listed clock first, then reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 op_valid  input  1  EX stage presents an HI/LO-class instruction.
REQ-005 op  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
REQ-006 rs_data  input  32  operand A (dividend, multiplicand, MT* source).
REQ-007 rt_data  input  32  operand B (divisor, multiplier).
REQ-008 stall  output  1  pipeline hold; op_valid/op/operands held stable by upstream while high.
REQ-009 hilo_rdata  output  32  HI for MFHI, LO for MFLO, else 0; combinational.
REQ-010 busy  output  1  multiply or divide in flight.
REQ-011 div_timeout  output  1  one-cycle pulse, divider failed to respond.
REQ-012 div_start, div_dividend[31:0], div_divisor[31:0]  outputs  divider request; operands registered.
REQ-013 div_done, div_quotient[31:0], div_remainder[31:0]  inputs  divider response; quotient to LO, remainder to HI.

Function
REQ-014 States SHALL be IDLE, MUL, DIV_GO, DIV_WAIT; busy = (state != IDLE).
REQ-015 An op is accepted only in IDLE with op_valid=1; stall = op_valid & busy, plus op_valid & op in {1,2,3} in the acceptance cycle.
REQ-016 MTHI/MTLO SHALL write HI/LO at the accepting edge without stalling; a following MFHI/MFLO sees the new value next cycle.
REQ-017 MFHI/MFLO in IDLE SHALL return HI/LO combinationally with no stall; while busy they stall until the cycle after HI/LO update.
REQ-018 MULT/MULTU: operands sign- (MULT) or zero- (MULTU) extended to 33 bits and registered at acceptance; state MUL for one cycle; {HI,LO} = low 64 bits of the product, written at the MUL exit edge (2-cycle latency, back in IDLE at T+2).
REQ-019 DIV with rt_data=0 SHALL NOT start the divider: HI=rs_data, LO=32'hFFFFFFFF at the accepting edge, no busy.
REQ-020 DIV otherwise: operands latched into div_dividend/div_divisor at acceptance and held unchanged until return to IDLE (the divider samples them every cycle); DIV_GO asserts div_start for exactly one cycle, then DIV_WAIT.
REQ-021 In DIV_WAIT, div_done=1 SHALL write LO=div_quotient and HI=div_remainder at that edge and return to IDLE; div_done is sampled only in DIV_WAIT.
REQ-022 div_done may arrive as early as the 2nd cycle after div_start (divider short-cut cases); no minimum wait is enforced.
REQ-023 A 6-bit wait counter clears on entry to DIV_WAIT; when it reaches DIV_TIMEOUT (40) without div_done, pulse div_timeout, leave HI/LO unchanged and return to IDLE.
REQ-024 op=0, or op_valid=0, SHALL change no state; DIVU is not supported and is never issued.
REQ-025 div_start and div_timeout are registered outputs; no combinational path from inputs to div_start.

Reset
REQ-026 With rst_n=0 at a clock edge: state=IDLE, HI=LO=0, operand registers=0, counter=0, div_start=0, div_timeout=0; therefore busy=0, stall=0, and hilo_rdata=0.
REQ-027 Reset mid-operation SHALL abandon the operation with no HI/LO write; the divider shares rst_n and resets in the same cycle.

Structure
REQ-028 Op codes, state encodings and DIV_TIMEOUT SHALL live in shared package muldiv_pkg.
REQ-029 The 33x33 signed multiply SHALL be a sub-module mult33; the divider is instantiated beside hilo_unit by the parent, not inside it.

Verification
REQ-030 MULT rs=FFFFFFFD, rt=7 -> stall for 2 cycles, then HI=FFFFFFFF, LO=FFFFFFEB.
REQ-031 MULTU rs=FFFFFFFF, rt=2 -> HI=00000001, LO=FFFFFFFE at T+2.
REQ-032 DIV rs=FFFFFFF9, rt=2 with real divider; MFLO issued next cycle -> stall until done+1, then hilo_rdata=FFFFFFFD, HI=FFFFFFFF.
REQ-033 DIV rs=1234, rt=0 -> no div_start, HI=00001234, LO=FFFFFFFF, busy never 1.
REQ-034 DIV with a divider model never asserting done -> div_timeout pulses 40 cycles into DIV_WAIT, HI/LO unchanged, then IDLE.
REQ-035 rst_n=0 in DIV_WAIT -> next cycle IDLE, HI=LO=0, div_start=0; a subsequent MTHI 5 then MFHI returns 5.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Holds the op codes presented by EX, the controller state encoding and the
// divider response timeout.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MFHI  = 3'd6,
        OP_MFLO  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL      = 2'd1,
        ST_DIV_GO   = 2'd2,
        ST_DIV_WAIT = 2'd3
    } state_e;

    // Cycles spent in DIV_WAIT without div_done before giving up.
    localparam int DIV_TIMEOUT = 40;
    localparam int CNT_W       = 6;

    // Ops that occupy the unit for more than the accepting cycle.
    function automatic logic is_long_op(input op_e o);
        return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/mult33.sv
// 33x33 signed multiplier, low 64 bits of the product.
// Ports:
//   a, b     : 33-bit two's-complement operands (already sign/zero extended)
//   product  : low 64 bits of a*b
module mult33 (
    input  logic [32:0] a,
    input  logic [32:0] b,
    output logic [63:0] product
);

    logic [63:0] a_ext;
    logic [63:0] b_ext;

    // The low 64 bits of a product do not depend on signedness once both
    // operands are sign-extended to the result width.
    assign a_ext   = {{31{a[32]}}, a};
    assign b_ext   = {{31{b[32]}}, b};
    assign product = a_ext * b_ext;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register unit: MULT/MULTU/DIV/MTHI/MTLO/MFHI/MFLO.
// Ports:
//   clk, rst_n                   : clock, synchronous active-low reset
//   op_valid, op, rs_data, rt_data : HI/LO-class instruction from EX
//   stall                        : hold request to the pipeline
//   hilo_rdata                   : HI for MFHI, LO for MFLO, else 0 (combinational)
//   busy                         : multiply or divide in flight
//   div_timeout                  : one-cycle pulse, divider never answered
//   div_start, div_dividend, div_divisor      : request to the external divider
//   div_done, div_quotient, div_remainder     : response from the external divider
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | ready; accepts ops, MT*/MF*/DIV-by-zero finish here
// ST_MUL      | registered operands in the multiplier; HI/LO written on exit
// ST_DIV_GO   | div_start high for this single cycle
// ST_DIV_WAIT | waiting for div_done, bounded by DIV_TIMEOUT cycles
module hilo_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        stall,
    output logic [31:0] hilo_rdata,
    output logic        busy,
    output logic        div_timeout,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_done,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder
);

    localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(DIV_TIMEOUT - 1);

    state_e            state_q, state_d;
    op_e               op_c;
    logic [31:0]       hi_q, lo_q;
    logic [32:0]       mul_a_q, mul_b_q;
    logic [63:0]       product;
    logic [CNT_W-1:0]  cnt_q;
    logic              div_zero;
    logic              div_start_d, div_timeout_d;

    assign op_c     = op_e'(op);
    assign div_zero = (rt_data == 32'd0);
    assign busy     = (state_q != ST_IDLE);
    assign stall    = op_valid && (busy || ((state_q == ST_IDLE) && is_long_op(op_c)));

    mult33 u_mult33 (
        .a       (mul_a_q),
        .b       (mul_b_q),
        .product (product)
    );

    always_comb begin
        hilo_rdata = '0;
        if (op_valid && op_c == OP_MFHI) begin
            hilo_rdata = hi_q;
        end else if (op_valid && op_c == OP_MFLO) begin
            hilo_rdata = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        div_start_d   = 1'b0;
        div_timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    if (op_c == OP_MULT || op_c == OP_MULTU) begin
                        state_d = ST_MUL;
                    end else if (op_c == OP_DIV && !div_zero) begin
                        state_d     = ST_DIV_GO;
                        div_start_d = 1'b1;
                    end
                end
            end
            ST_MUL:    state_d = ST_IDLE;
            ST_DIV_GO: state_d = ST_DIV_WAIT;
            ST_DIV_WAIT: begin
                if (div_done) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == TIMEOUT_TC) begin
                    state_d       = ST_IDLE;
                    div_timeout_d = 1'b1;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q         <= '0;
            lo_q         <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            cnt_q        <= '0;
            div_start    <= 1'b0;
            div_timeout  <= 1'b0;
        end else begin
            div_start   <= div_start_d;
            div_timeout <= div_timeout_d;
            case (state_q)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (op_c)
                            OP_MULT: begin
                                mul_a_q <= {rs_data[31], rs_data};
                                mul_b_q <= {rt_data[31], rt_data};
                            end
                            OP_MULTU: begin
                                mul_a_q <= {1'b0, rs_data};
                                mul_b_q <= {1'b0, rt_data};
                            end
                            OP_DIV: begin
                                // Divide by zero resolves locally; divider is never started.
                                if (div_zero) begin
                                    hi_q <= rs_data;
                                    lo_q <= 32'hFFFF_FFFF;
                                end else begin
                                    div_dividend <= rs_data;
                                    div_divisor  <= rt_data;
                                end
                            end
                            OP_MTHI: hi_q <= rs_data;
                            OP_MTLO: lo_q <= rs_data;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: {hi_q, lo_q} <= product;
                ST_DIV_GO: cnt_q <= '0;
                ST_DIV_WAIT: begin
                    if (div_done) begin
                        lo_q <= div_quotient;
                        hi_q <= div_remainder;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit with a behavioural divider beside it.
module tb_hilo_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        stall, busy, div_timeout, div_start;
    logic [31:0] hilo_rdata, div_dividend, div_divisor;
    logic        div_done = 1'b0;
    logic [31:0] div_quotient = '0;
    logic [31:0] div_remainder = '0;

    int n_vec = 0;
    int n_err = 0;
    int div_lat = 3;
    bit div_never = 1'b0;
    int div_cnt = 0;

    logic [31:0] hi_m, lo_m;

    typedef struct {
        op_e         o;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[13];

    hilo_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op_valid      (op_valid),
        .op            (op),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .stall         (stall),
        .hilo_rdata    (hilo_rdata),
        .busy          (busy),
        .div_timeout   (div_timeout),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    always #5 clk = ~clk;

    // Divider model: done is seen by the DUT at the edge ending cycle start+div_lat.
    always @(negedge clk) begin
        div_done = 1'b0;
        if (!rst_n) begin
            div_cnt = 0;
        end else begin
            if (div_cnt > 0) begin
                div_cnt--;
                if (div_cnt == 0) begin
                    div_done      = 1'b1;
                    div_quotient  = $signed(div_dividend) / $signed(div_divisor);
                    div_remainder = $signed(div_dividend) % $signed(div_divisor);
                end
            end
            if (div_start && !div_never) div_cnt = div_lat;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 200) begin
            tick();
            k++;
        end
        check(name, {31'b0, busy}, 32'd0);
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        op_valid = 1'b1;
        op = OP_MFHI;
        #1;
        h = hilo_rdata;
        op = OP_MFLO;
        #1;
        l = hilo_rdata;
        op_valid = 1'b0;
        op = OP_NOP;
    endtask

    task automatic do_op(input bit v, input op_e o, input logic [31:0] a, input logic [31:0] b);
        op_valid = v;
        op = o;
        rs_data = a;
        rt_data = b;
        tick();
        op_valid = 1'b0;
        op = OP_NOP;
        wait_idle("op_complete");
    endtask

    function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint x, y;
        if (sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'b0, a});
            y = longint'({32'b0, b});
        end
        return 64'(x * y);
    endfunction

    initial begin
        logic [31:0] h, l;
        int stalls, starts, s_at, t_at, k;
        bit seen_busy, seen_start;
        op_e o;
        logic [31:0] a, b;
        bit v;

        tbl[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        tbl[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
        tbl[2]  = '{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        tbl[3]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tbl[4]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[5]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        tbl[6]  = '{OP_DIV,   32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
        tbl[7]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[8]  = '{OP_DIV,   32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        tbl[9]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        tbl[10] = '{OP_MTHI,  32'hA5A5A5A5, 32'd9,        32'hA5A5A5A5, 32'hFFFFFFFD};
        tbl[11] = '{OP_MTLO,  32'h5A5A5A5A, 32'd9,        32'hA5A5A5A5, 32'h5A5A5A5A};
        tbl[12] = '{OP_NOP,   32'h13572468, 32'd1,        32'hA5A5A5A5, 32'h5A5A5A5A};

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        op_valid = 1'b1;
        op = OP_MFHI;
        @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_stall", {31'b0, stall}, 32'd0);
        check("reset_rdata", hilo_rdata, 32'd0);
        check("reset_div_start", {31'b0, div_start}, 32'd0);
        check("reset_div_timeout", {31'b0, div_timeout}, 32'd0);
        op_valid = 1'b0;
        op = OP_NOP;
        tick();
        rst_n = 1'b1;
        tick();

        // Table-driven vectors
        for (int i = 0; i < 13; i++) begin
            div_lat = 3;
            do_op(1'b1, tbl[i].o, tbl[i].rs, tbl[i].rt);
            read_hilo(h, l);
            check($sformatf("tbl%0d_hi", i), h, tbl[i].hi);
            check($sformatf("tbl%0d_lo", i), l, tbl[i].lo);
        end

        // MULT stall timing and 2-cycle latency
        op_valid = 1'b1;
        op = OP_MULT;
        rs_data = 32'hFFFFFFFD;
        rt_data = 32'd7;
        @(negedge clk);
        check("mult_stall_accept", {31'b0, stall}, 32'd1);
        tick();
        op = OP_MFHI;
        @(negedge clk);
        check("mult_stall_busy", {31'b0, stall}, 32'd1);
        check("mult_busy", {31'b0, busy}, 32'd1);
        tick();
        @(negedge clk);
        check("mult_stall_done", {31'b0, stall}, 32'd0);
        check("mult_hi", hilo_rdata, 32'hFFFFFFFF);
        op = OP_MFLO;
        #1;
        check("mult_lo", hilo_rdata, 32'hFFFFFFEB);
        op_valid = 1'b0;
        op = OP_NOP;
        tick();

        // DIV with real divider, MFLO right behind it
        div_lat = 3;
        op_valid = 1'b1;
        op = OP_DIV;
        rs_data = 32'hFFFFFFF9;
        rt_data = 32'd2;
        tick();
        op = OP_MFLO;
        rs_data = $urandom;
        rt_data = $urandom;
        stalls = 0;
        starts = 0;
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            if (div_start) starts++;
            if (!stall) break;
            stalls++;
            tick();
            k++;
        end
        check("div_stall_cycles", 32'(stalls), 32'(div_lat + 1));
        check("div_start_pulses", 32'(starts), 32'd1);
        check("div_lo", hilo_rdata, 32'hFFFFFFFD);
        check("div_dividend_held", div_dividend, 32'hFFFFFFF9);
        check("div_divisor_held", div_divisor, 32'd2);
        op = OP_MFHI;
        #1;
        check("div_hi", hilo_rdata, 32'hFFFFFFFF);
        op_valid = 1'b0;
        op = OP_NOP;
        tick();

        // DIV by zero: no divider, no busy
        op_valid = 1'b1;
        op = OP_DIV;
        rs_data = 32'h00001234;
        rt_data = 32'd0;
        seen_busy = 1'b0;
        seen_start = 1'b0;
        tick();
        op = OP_MFHI;
        @(negedge clk);
        check("div0_stall", {31'b0, stall}, 32'd0);
        check("div0_hi", hilo_rdata, 32'h00001234);
        op = OP_MFLO;
        #1;
        check("div0_lo", hilo_rdata, 32'hFFFFFFFF);
        op_valid = 1'b0;
        op = OP_NOP;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen_busy  = seen_busy | busy;
            seen_start = seen_start | div_start;
        end
        check("div0_busy_seen", {31'b0, seen_busy}, 32'd0);
        check("div0_start_seen", {31'b0, seen_start}, 32'd0);
        tick();

        // MTHI then MFHI next cycle
        op_valid = 1'b1;
        op = OP_MTHI;
        rs_data = 32'hDEADBEEF;
        @(negedge clk);
        check("mthi_stall", {31'b0, stall}, 32'd0);
        tick();
        op = OP_MFHI;
        #1;
        check("mthi_mfhi", hilo_rdata, 32'hDEADBEEF);
        op_valid = 1'b0;
        op = OP_NOP;

        // Divider timeout
        do_op(1'b1, OP_MTHI, 32'h11111111, 32'd0);
        do_op(1'b1, OP_MTLO, 32'h22222222, 32'd0);
        div_never = 1'b1;
        op_valid = 1'b1;
        op = OP_DIV;
        rs_data = 32'd9;
        rt_data = 32'd3;
        tick();
        op_valid = 1'b0;
        op = OP_NOP;
        s_at = -1000;
        t_at = 1000;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (div_start) s_at = c;
            if (div_timeout) begin
                t_at = c;
                check("timeout_busy", {31'b0, busy}, 32'd0);
                break;
            end
            tick();
        end
        check("timeout_cycles", 32'(t_at - s_at), 32'(DIV_TIMEOUT + 1));
        tick();
        @(negedge clk);
        check("timeout_width", {31'b0, div_timeout}, 32'd0);
        read_hilo(h, l);
        check("timeout_hi", h, 32'h11111111);
        check("timeout_lo", l, 32'h22222222);
        tick();

        // Reset during DIV_WAIT
        op_valid = 1'b1;
        op = OP_DIV;
        rs_data = 32'd50;
        rt_data = 32'd5;
        tick();
        op_valid = 1'b0;
        op = OP_NOP;
        for (int i = 0; i < 6; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_div_start", {31'b0, div_start}, 32'd0);
        read_hilo(h, l);
        check("rst_hi", h, 32'd0);
        check("rst_lo", l, 32'd0);
        div_never = 1'b0;
        tick();
        op_valid = 1'b1;
        op = OP_MTHI;
        rs_data = 32'd5;
        tick();
        op = OP_MFHI;
        #1;
        check("rst_mthi_mfhi", hilo_rdata, 32'd5);
        op_valid = 1'b0;
        op = OP_NOP;
        tick();

        // Randomized ops against the reference model
        hi_m = 32'd5;
        lo_m = 32'd0;
        for (int i = 0; i < 80; i++) begin
            o = op_e'($urandom_range(0, 5));
            a = $urandom;
            b = $urandom;
            v = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 20));
            if (o == OP_DIV && $urandom_range(0, 3) == 0) b = 32'd0;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
            div_lat = $urandom_range(1, 6);
            if (v) begin
                case (o)
                    OP_MULT:  {hi_m, lo_m} = ref_mult(a, b, 1'b1);
                    OP_MULTU: {hi_m, lo_m} = ref_mult(a, b, 1'b0);
                    OP_DIV: begin
                        if (b == 32'd0) begin
                            hi_m = a;
                            lo_m = 32'hFFFFFFFF;
                        end else begin
                            lo_m = $signed(a) / $signed(b);
                            hi_m = $signed(a) % $signed(b);
                        end
                    end
                    OP_MTHI:  hi_m = a;
                    OP_MTLO:  lo_m = a;
                    default: ;
                endcase
            end
            do_op(v, o, a, b);
            read_hilo(h, l);
            check($sformatf("rnd%0d_hi", i), h, hi_m);
            check($sformatf("rnd%0d_lo", i), l, lo_m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
